// File: rtl/reaction_score_keeper_pkg.sv
// Shared constants and helpers for the reaction score keeper.
package reaction_score_keeper_pkg;

  localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;
  localparam logic [15:0] BEST_INIT     = 16'h9999;

  // Active-low segment codes, bit order [0:6] = a..g
  localparam logic [0:6] SEG_0 = 7'b0000001;
  localparam logic [0:6] SEG_1 = 7'b1001111;
  localparam logic [0:6] SEG_2 = 7'b0010010;
  localparam logic [0:6] SEG_3 = 7'b0000110;
  localparam logic [0:6] SEG_4 = 7'b1001100;
  localparam logic [0:6] SEG_5 = 7'b0100100;
  localparam logic [0:6] SEG_6 = 7'b0100000;
  localparam logic [0:6] SEG_7 = 7'b0001111;
  localparam logic [0:6] SEG_8 = 7'b0000000;
  localparam logic [0:6] SEG_9 = 7'b0000100;

  // A packed 4-digit result is legal when every nibble is a decimal digit
  function automatic logic bcd_is_legal(input logic [15:0] value);
    bcd_is_legal = (value[3:0]   <= BCD_DIGIT_MAX) &&
                   (value[7:4]   <= BCD_DIGIT_MAX) &&
                   (value[11:8]  <= BCD_DIGIT_MAX) &&
                   (value[15:12] <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/hexdisplay.sv
// Single-digit BCD to active-low 7-segment decoder; non-decimal input shows "0".
module hexdisplay
  import reaction_score_keeper_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);

  // Digit lookup
  always_comb begin
    case (bcd)
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/reaction_history_ram.sv
// Ring storage of the most recent results, with write pointer and fill count.
module reaction_history_ram
  import reaction_score_keeper_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [15:0]      wr_data,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [15:0]      rd_data,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] COUNT_MAX = (PTR_W+1)'(DEPTH);

  logic [15:0] mem [DEPTH];

  // Storage array; contents are don't-care after reset because count gates visibility
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Write pointer wraps naturally; count saturates once the ring is full
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != COUNT_MAX) count <= count + 1'b1;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/reaction_score_keeper.sv
// Keeps recent reaction-timer results, tracks the best time and drives the HEX digits.
module reaction_score_keeper
  import reaction_score_keeper_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Result_valid,
  input  logic [15:0]      Result_bcd,
  input  logic             Browse_button,
  input  logic             Show_best,
  output logic             New_best,
  output logic             Best_valid,
  output logic             Bad_result,
  output logic [PTR_W:0]   Count,
  output logic [15:0]      Disp_bcd,
  output logic [0:6]       y0,
  output logic [0:6]       y1,
  output logic [0:6]       y2,
  output logic [0:6]       y3
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic             capture;
  logic             press;
  logic             browse_prev;
  logic [PTR_W-1:0] view_ofs;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_idx;
  logic [15:0]      rd_data;
  logic [15:0]      best;
  logic [15:0]      sel;

  assign capture = Result_valid && bcd_is_legal(Result_bcd);
  assign press   = browse_prev && !Browse_button;
  // Newest entry sits just behind the write pointer; modulo comes from pointer width
  assign rd_idx  = wr_ptr - PTR_ONE - view_ofs;

  reaction_history_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_hist (
    .Clock   (Clock),
    .Reset   (Reset),
    .wr_en   (capture),
    .wr_data (Result_bcd),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_ptr  (wr_ptr),
    .count   (Count)
  );

  // Best time tracking, sticky bad-result flag and one-cycle improvement pulse
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      best       <= BEST_INIT;
      Best_valid <= 1'b0;
      New_best   <= 1'b0;
      Bad_result <= 1'b0;
    end else begin
      New_best <= 1'b0;
      if (Result_valid && !capture) Bad_result <= 1'b1;
      if (capture && (!Best_valid || Result_bcd < best)) begin
        best       <= Result_bcd;
        Best_valid <= 1'b1;
        New_best   <= 1'b1;
      end
    end
  end

  // Browse offset: a capture snaps back to newest, a press steps older and wraps
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      browse_prev <= 1'b1;
      view_ofs    <= '0;
    end else begin
      browse_prev <= Browse_button;
      if (capture) begin
        view_ofs <= '0;
      end else if (press && Count != '0) begin
        if ({1'b0, view_ofs} == Count - 1'b1) view_ofs <= '0;
        else                                 view_ofs <= view_ofs + 1'b1;
      end
    end
  end

  // Display source selection
  always_comb begin
    sel = 16'h0000;
    if (Show_best) begin
      if (Best_valid) sel = best;
    end else if (Count != '0) begin
      sel = rd_data;
    end
  end

  // Registered display value
  always_ff @(posedge Clock) begin
    if (!Reset) Disp_bcd <= 16'h0000;
    else        Disp_bcd <= sel;
  end

  hexdisplay u_hex0 (.bcd(Disp_bcd[3:0]),   .seg(y0));
  hexdisplay u_hex1 (.bcd(Disp_bcd[7:4]),   .seg(y1));
  hexdisplay u_hex2 (.bcd(Disp_bcd[11:8]),  .seg(y2));
  hexdisplay u_hex3 (.bcd(Disp_bcd[15:12]), .seg(y3));

endmodule

// File: tb/tb_reaction_score_keeper.sv
// Self-checking bench for reaction_score_keeper: directed table, corner sequences, random vs model.
module tb_reaction_score_keeper;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             Clock;
  logic             Reset;
  logic             Result_valid;
  logic [15:0]      Result_bcd;
  logic             Browse_button;
  logic             Show_best;
  logic             New_best;
  logic             Best_valid;
  logic             Bad_result;
  logic [PTR_W:0]   Count;
  logic [15:0]      Disp_bcd;
  logic [0:6]       y0, y1, y2, y3;

  reaction_score_keeper #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Result_valid  (Result_valid),
    .Result_bcd    (Result_bcd),
    .Browse_button (Browse_button),
    .Show_best     (Show_best),
    .New_best      (New_best),
    .Best_valid    (Best_valid),
    .Bad_result    (Bad_result),
    .Count         (Count),
    .Disp_bcd      (Disp_bcd),
    .y0            (y0),
    .y1            (y1),
    .y2            (y2),
    .y3            (y3)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: history newest-first, plus best/flags and the displayed value
  logic [15:0] hist[$];
  int          view;
  logic [15:0] m_best;
  bit          m_bv, m_bad, m_nb, m_prev;
  logic [15:0] m_disp;

  logic [6:0] seg_tab [10];

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          nb;
    int          cnt;
    logic [15:0] disp;
    bit          bad;
  } vec_t;
  vec_t tbl [10];

  logic [15:0] exp_browse [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [15:0] v);
    for (int i = 0; i < 4; i++)
      if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    if (n > 4'd9) return seg_tab[0];
    return seg_tab[n];
  endfunction

  task automatic check_model();
    chk("count",      32'(Count),      32'(hist.size()));
    chk("best_valid", 32'(Best_valid), 32'(m_bv));
    chk("bad_result", 32'(Bad_result), 32'(m_bad));
    chk("new_best",   32'(New_best),   32'(m_nb));
    chk("disp_bcd",   32'(Disp_bcd),   32'(m_disp));
    chk("y0", 32'(y0), 32'(seg_of(m_disp[3:0])));
    chk("y1", 32'(y1), 32'(seg_of(m_disp[7:4])));
    chk("y2", 32'(y2), 32'(seg_of(m_disp[11:8])));
    chk("y3", 32'(y3), 32'(seg_of(m_disp[15:12])));
  endtask

  // One clock cycle: drive inputs at negedge, advance model at posedge, compare at next negedge
  task automatic step(input bit v, input logic [15:0] d, input bit btn, input bit sb, input bit rst);
    logic [15:0] sel;
    bit press, cap;
    Result_valid  = v;
    Result_bcd    = d;
    Browse_button = btn;
    Show_best     = sb;
    Reset         = rst;
    @(posedge Clock);
    if (!rst) begin
      hist.delete();
      view = 0; m_best = 16'h9999; m_bv = 0; m_bad = 0; m_nb = 0; m_prev = 1; m_disp = 16'h0;
    end else begin
      if (sb) sel = m_bv ? m_best : 16'h0;
      else    sel = (hist.size() > 0) ? hist[view] : 16'h0;
      m_disp = sel;
      press  = m_prev && !btn;
      m_prev = btn;
      m_nb   = 0;
      cap    = v && legal(d);
      if (v && !cap) m_bad = 1;
      if (cap) begin
        hist.push_front(d);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        view = 0;
        if (!m_bv || d < m_best) begin
          m_best = d; m_bv = 1; m_nb = 1;
        end
      end else if (press && hist.size() > 0) begin
        view = (view + 1) % hist.size();
      end
    end
    @(negedge Clock);
    check_model();
  endtask

  initial begin
    bit btn, sb, v;
    logic [15:0] d;

    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    tbl[0] = '{1'b1, 16'h0234, 1'b1, 1, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 16'h0000, 1'b0, 1, 16'h0234, 1'b0};
    tbl[2] = '{1'b1, 16'h0187, 1'b1, 2, 16'h0234, 1'b0};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 2, 16'h0187, 1'b0};
    tbl[4] = '{1'b1, 16'h0187, 1'b0, 3, 16'h0187, 1'b0};
    tbl[5] = '{1'b1, 16'h0301, 1'b0, 4, 16'h0187, 1'b0};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 4, 16'h0187, 1'b0};
    tbl[7] = '{1'b1, 16'h01A5, 1'b0, 4, 16'h0187, 1'b1};
    tbl[8] = '{1'b1, 16'h0099, 1'b1, 5, 16'h0187, 1'b1};
    tbl[9] = '{1'b0, 16'h0000, 1'b0, 5, 16'h0099, 1'b1};

    exp_browse = '{16'h0109, 16'h0108, 16'h0107, 16'h0106,
                   16'h0105, 16'h0104, 16'h0103, 16'h0110};

    // Reset, then idle
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 1, 0, 1);
    step(0, 16'h0, 1, 0, 1);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_best_valid", 32'(Best_valid), 32'd0);
    chk("rst_bad", 32'(Bad_result), 32'd0);
    chk("rst_disp", 32'(Disp_bcd), 32'h0000);
    chk("rst_y", {4'h0, y3, y2, y1, y0}, {4'h0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001});

    // Directed table: best tracking, ties, illegal result
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].d, 1, 1, 1);
      chk($sformatf("tbl%0d_new_best", i), 32'(New_best),   32'(tbl[i].nb));
      chk($sformatf("tbl%0d_count", i),    32'(Count),      32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_disp", i),     32'(Disp_bcd),   32'(tbl[i].disp));
      chk($sformatf("tbl%0d_bad", i),      32'(Bad_result), 32'(tbl[i].bad));
    end

    // Wrap-around fill and browsing
    step(0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      d = 16'h0101 + 16'(i);
      if (i == 9) d = 16'h0110;
      step(1, d, 1, 0, 1);
    end
    step(0, 16'h0, 1, 0, 1);
    chk("fill_count", 32'(Count), 32'd8);
    chk("fill_newest", 32'(Disp_bcd), 32'h0110);
    for (int k = 0; k < 8; k++) begin
      step(0, 16'h0, 0, 0, 1);
      step(0, 16'h0, 1, 0, 1);
      chk($sformatf("browse%0d", k), 32'(Disp_bcd), 32'(exp_browse[k]));
    end
    for (int k = 0; k < 100; k++) step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 1, 0, 1);
    chk("hold_one_step", 32'(Disp_bcd), 32'h0109);

    // Capture and press edge in the same cycle
    step(1, 16'h0450, 0, 0, 1);
    step(0, 16'h0, 1, 0, 1);
    chk("cap_vs_press", 32'(Disp_bcd), 32'h0450);
    step(0, 16'h0, 1, 0, 1);
    chk("cap_vs_press_hold", 32'(Disp_bcd), 32'h0450);

    // Reset in the same cycle as a result
    step(1, 16'h0050, 1, 1, 0);
    chk("rst_cap_new_best", 32'(New_best), 32'd0);
    chk("rst_cap_count", 32'(Count), 32'd0);
    step(0, 16'h0, 1, 1, 1);
    chk("rst_cap_best_valid", 32'(Best_valid), 32'd0);
    chk("rst_cap_disp", 32'(Disp_bcd), 32'h0000);

    // Random traffic against the model
    btn = 1; sb = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)  btn = ~btn;
      if ($urandom_range(0, 40) == 0) sb = ~sb;
      v = ($urandom_range(0, 3) == 0);
      d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 15) == 0) d[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      step(v, d, btn, sb, ($urandom_range(0, 499) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_score_keeper.md
Name: reaction_score_keeper

Overview:
- Consumer of the reaction timer's 4-digit BCD result (BCD3..BCD0, 10 ms resolution).
- Stores the last DEPTH measurements in a ring buffer and tracks the best (minimum) time.
- Lets the user browse history with a push button and drives four 7-segment digits.
- Sits between the reaction timer core and the board's HEX displays; the timer writes, this block reads.

Parameters:
- DEPTH, 8, number of stored results; power of two, 2..16.
- PTR_W, 3, log2(DEPTH); pointer width.

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-low
- Result_valid  in  1  one-cycle high pulse; Result_bcd holds a completed measurement
- Result_bcd  in  16  {BCD3,BCD2,BCD1,BCD0}, BCD3 most significant
- Browse_button  in  1  active-low push button, already synchronous to Clock
- Show_best  in  1  level; 1 = display best time, 0 = display history entry
- New_best  out  1  one-cycle pulse when the best time improves
- Best_valid  out  1  high once any legal result is stored
- Bad_result  out  1  sticky flag: a result with a digit >9 was rejected
- Count  out  PTR_W+1  number of stored entries, saturates at DEPTH
- Disp_bcd  out  16  BCD value currently displayed
- y0,y1,y2,y3  out  [0:6] each  segment codes for Disp_bcd digits 0..3; y3 = leftmost digit

Behaviour:
- Reset (Reset==0 at posedge): all outputs and state return to fixed values.
  - wr_ptr=0, Count=0, view_ofs=0, Best_valid=0, best=16'h9999, New_best=0, Bad_result=0, Disp_bcd=16'h0000.
  - Buffer contents are don't-care.
  - y0..y3 show "0000".
- Reset mid-operation discards everything, including a Result_valid pulse in the same cycle.
- Legality: a result is legal iff every nibble <=9. An illegal result is dropped, sets Bad_result, and changes no other state. Bad_result clears only on Reset.
- Capture (cycle N: Result_valid=1 and result legal). At posedge N+1:
  - mem[wr_ptr] <= Result_bcd.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - Count <= min(Count+1, DEPTH).
  - view_ofs <= 0, so the view snaps to the newest entry.
- When the buffer is full, a capture overwrites the oldest entry; Count stays at DEPTH.
- Best (same edge): if Result_bcd < best (unsigned 16-bit compare, valid because packed BCD ordering equals numeric ordering) or Best_valid==0:
  - best <= Result_bcd, Best_valid <= 1, New_best=1 for exactly one cycle.
  - Ties do not update best and do not pulse.
  - 0000 is a legal result and becomes best.
- Browse: press = Browse_button sampled 1 then 0 on consecutive edges, detected with a registered previous value. Each press increments view_ofs, moving to the next older entry.
  - When view_ofs==Count-1, the next press wraps to 0.
  - With Count==0, presses are ignored.
  - Holding the button gives one step only.
- Simultaneous capture and press edge: capture wins; view_ofs=0.
- Display selection:
  - Show_best=1 and Best_valid=1: sel=best.
  - Show_best=1 and Best_valid=0: sel=0000.
  - Show_best=0 and Count>0: sel=mem[(wr_ptr-1-view_ofs) mod DEPTH].
  - Show_best=0 and Count==0: sel=0000.
- Disp_bcd is registered from sel. y0..y3 are combinational decodes of Disp_bcd.
- Latency: a result pulsed in cycle N appears on Disp_bcd and y* after posedge N+2. A Show_best change or browse step shows one cycle after its state update.
- Segment encoding is active-low, bit order [0:6]=a..g. Digits 0-9 use the standard codes; any other nibble shows "0".

Decomposition:
- Shared package holds:
  - BCD_DIGIT_MAX=4'd9
  - BEST_INIT=16'h9999
  - the 7-segment digit code constants
  - a function for the nibble legality check
- Sub-module reaction_history_ram: DEPTH x 16 ring storage with the write pointer and Count.
  - Interface: write enable and data in; asynchronous read at an index.
- 7-segment decode: four instances of the existing hexdisplay decoder.

Test Plan:
- Reset, then no activity -> Count=0, Best_valid=0, Disp_bcd=0000, y3..y0 all 7'b0000001, Bad_result=0.
- Results 0234, 0187, 0187, 0301 (Show_best=1) -> New_best pulses after the 1st and 2nd only; best=0187; Disp_bcd=0187 two cycles after the 2nd pulse; Count=4.
- Result 01A5 -> dropped; Bad_result=1; Count and best unchanged. Then 0099 -> stored, best=0099, Bad_result still 1.
- Ten results 0101..0110 with DEPTH=8, Show_best=0 -> Count=8; newest 0110 displayed. Eight presses step 0109..0103, then wrap to 0110. Holding the button low for 100 cycles gives one step.
- Browse press in the same cycle as Result_valid (0450) -> Disp_bcd=0450, view_ofs=0.
- Reset asserted in the same cycle as Result_valid=1 with 0050 -> after reset all state is initial; 0050 is not stored and New_best does not pulse.
